// File: rtl/divider_controller.sv
// Programmable frequency-divider controller: free-running counter with a selectable
// 8-bit window, plus a divide-by-2(N+1) square wave whose ratio changes only at half-period boundaries.
module divider_controller #(
    parameter int WIDTH   = 32,
    parameter int TAP_W   = 5,
    parameter int MAX_TAP = WIDTH - 8
) (
    input  logic             clkC,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [TAP_W-1:0] cfg_tap,
    output logic             div_out,
    output logic             tick,
    output logic [7:0]       prescaled,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        PENDING = 2'b10
    } state_t;

    localparam logic [TAP_W-1:0] RESET_TAP = TAP_W'(22);
    localparam logic [TAP_W-1:0] TAP_LIMIT = TAP_W'(MAX_TAP);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] free_cnt_reg;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] div_reg, div_next;
    logic [WIDTH-1:0] div_sh_reg, div_sh_next;
    logic [TAP_W-1:0] tap_reg, tap_next;
    logic [TAP_W-1:0] tap_sh_reg, tap_sh_next;
    logic             div_out_reg, div_out_next;
    logic             tick_reg, tick_next;

    logic             handshake;
    logic             terminal;
    logic [TAP_W-1:0] tap_clamped;

    assign cfg_ready   = (state_reg != PENDING);
    assign handshake   = cfg_valid && cfg_ready;
    assign terminal    = (cnt_reg == div_reg);
    assign tap_clamped = (cfg_tap > TAP_LIMIT) ? TAP_LIMIT : cfg_tap;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        div_next     = div_reg;
        tap_next     = tap_reg;
        div_sh_next  = div_sh_reg;
        tap_sh_next  = tap_sh_reg;
        div_out_next = div_out_reg;
        tick_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (handshake) begin
                    div_next   = cfg_div;
                    tap_next   = tap_clamped;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (enable) begin
                    if (terminal) begin
                        cnt_next     = '0;
                        div_out_next = ~div_out_reg;
                        tick_next    = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                // A request landing on a terminal edge still toggles with the old ratio.
                if (handshake) begin
                    div_sh_next = cfg_div;
                    tap_sh_next = tap_clamped;
                    state_next  = PENDING;
                end
            end
            PENDING: begin
                if (enable) begin
                    if (terminal) begin
                        cnt_next     = '0;
                        div_out_next = ~div_out_reg;
                        tick_next    = 1'b1;
                        div_next     = div_sh_reg;
                        tap_next     = tap_sh_reg;
                        state_next   = RUN;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clkC) begin
        if (reset) begin
            state_reg    <= IDLE;
            free_cnt_reg <= '0;
            cnt_reg      <= '0;
            div_reg      <= '0;
            tap_reg      <= RESET_TAP;
            div_sh_reg   <= '0;
            tap_sh_reg   <= RESET_TAP;
            div_out_reg  <= 1'b0;
            tick_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            free_cnt_reg <= free_cnt_reg + 1'b1;
            cnt_reg      <= cnt_next;
            div_reg      <= div_next;
            tap_reg      <= tap_next;
            div_sh_reg   <= div_sh_next;
            tap_sh_reg   <= tap_sh_next;
            div_out_reg  <= div_out_next;
            tick_reg     <= tick_next;
        end
    end

    // Tap is clamped on entry, so tap_reg + 7 always stays inside free_cnt_reg.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_window
            assign prescaled[gi] = free_cnt_reg[tap_reg + TAP_W'(gi)];
        end
    endgenerate

    assign div_out = div_out_reg;
    assign tick    = tick_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_divider_controller.sv
// Bench for divider_controller: directed scenarios then random traffic, checked every
// cycle against a cycles-remaining reference model of the divider.
module tb_divider_controller;

    logic        clkC = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_div;
    logic [4:0]  cfg_tap;
    logic        div_out;
    logic        tick;
    logic [7:0]  prescaled;
    logic [1:0]  state;

    divider_controller dut (
        .clkC      (clkC),
        .reset     (reset),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_tap   (cfg_tap),
        .div_out   (div_out),
        .tick      (tick),
        .prescaled (prescaled),
        .state     (state)
    );

    always #5 clkC = ~clkC;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: configured/pending flags, cycles left in the current half-period.
    bit              m_cfgd;
    bit              m_pend;
    bit [31:0]       m_n, m_sh_n;
    int unsigned     m_tap, m_sh_tap;
    longint unsigned m_left;
    bit              m_out, m_tick;
    bit [31:0]       m_free;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned clamp_tap(input logic [4:0] t);
        return (int'(t) > 24) ? 24 : int'(t);
    endfunction

    task automatic model_edge();
        bit hs;
        if (reset) begin
            m_cfgd = 0; m_pend = 0; m_n = 0; m_sh_n = 0;
            m_tap = 22; m_sh_tap = 22; m_left = 0;
            m_out = 0; m_tick = 0; m_free = 0;
            return;
        end
        m_free = m_free + 1;
        hs = cfg_valid && !m_pend;
        m_tick = 0;
        if (!m_cfgd) begin
            if (hs) begin
                m_cfgd = 1;
                m_n    = cfg_div;
                m_tap  = clamp_tap(cfg_tap);
                m_left = longint'(cfg_div) + 1;
                $display("cycle %0d: config accepted in IDLE div=%0d tap=%0d", cyc, cfg_div, cfg_tap);
            end
            return;
        end
        if (enable) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_out  = !m_out;
                m_tick = 1;
                if (m_pend) begin
                    m_pend = 0;
                    m_n    = m_sh_n;
                    m_tap  = m_sh_tap;
                end
                m_left = longint'(m_n) + 1;
            end
        end
        if (hs) begin
            m_pend   = 1;
            m_sh_n   = cfg_div;
            m_sh_tap = clamp_tap(cfg_tap);
            $display("cycle %0d: config queued while running div=%0d tap=%0d", cyc, cfg_div, cfg_tap);
        end
    endtask

    task automatic compare();
        logic [1:0] exp_state;
        logic [7:0] exp_pre;
        exp_state = !m_cfgd ? 2'b00 : (m_pend ? 2'b10 : 2'b01);
        exp_pre   = 8'((m_free >> m_tap) & 32'hFF);
        check("div_out",   32'(div_out),   32'(m_out));
        check("tick",      32'(tick),      32'(m_tick));
        check("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        check("state",     32'(state),     32'(exp_state));
        check("prescaled", 32'(prescaled), 32'(exp_pre));
    endtask

    task automatic step();
        @(posedge clkC);
        model_edge();
        #1;
        compare();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg(input logic [31:0] d, input logic [4:0] t);
        cfg_valid = 1'b1;
        cfg_div   = d;
        cfg_tap   = t;
        step();
        cfg_valid = 1'b0;
    endtask

    int         ticks, highs, waited;
    logic [7:0] p0;

    initial begin
        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_tap = '0;
        run(2);
        reset = 1'b0; enable = 1'b1;
        run(40);
        check("idle_state", 32'(state), 32'd0);

        // N=3, tap 0: 4-cycle half periods
        cfg(32'd3, 5'd0);
        ticks = 0; highs = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            ticks += int'(tick);
            highs += int'(div_out);
        end
        check("tick_count_n3", 32'(ticks), 32'd10);
        check("high_count_n3", 32'(highs), 32'd20);

        // Reload N=1 two cycles after a toggle
        waited = 0;
        while (!m_tick && waited < 20) begin step(); waited++; end
        check("wait_tick_bound", 32'(m_tick), 32'd1);
        run(2);
        cfg(32'd1, 5'd0);
        check("pending_after_hs", 32'(state), 32'd2);
        run(20);

        // N=2 then a request coincident with a terminal count
        cfg(32'd2, 5'd0);
        run(12);
        waited = 0;
        while ((m_left != 1 || m_pend) && waited < 50) begin step(); waited++; end
        check("wait_terminal_bound", 32'(m_left), 32'd1);
        cfg(32'd5, 5'd0);
        check("coincident_tick", 32'(tick), 32'd1);
        run(30);

        // N=4, freeze mid half-period
        cfg(32'd4, 5'd0);
        run(15);
        waited = 0;
        while (!m_tick && waited < 20) begin step(); waited++; end
        run(2);
        enable = 1'b0;
        p0 = prescaled;
        run(10);
        check("free_advance", 32'(8'(prescaled - p0)), 32'd10);
        enable = 1'b1;
        run(20);

        // Tap clamp
        cfg(32'd3, 5'd30);
        run(20);

        // Reset while PENDING discards the shadow
        cfg(32'd6, 5'd1);
        check("pending_before_reset", 32'(cfg_ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_state", 32'(state), 32'd0);
        check("reset_ready", 32'(cfg_ready), 32'd1);
        run(20);

        // N=0: continuous tick, then the maximum ratio
        cfg(32'd0, 5'd0);
        run(10);
        check("n0_tick", 32'(tick), 32'd1);
        cfg(32'hFFFF_FFFF, 5'd5);
        run(10);
        cfg(32'd2, 5'd3);
        run(10);
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_div   = $urandom_range(0, 6);
            cfg_tap   = 5'($urandom_range(0, 31));
            reset     = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
